// File: rtl/clock_mode_controller.sv
// clock_mode_controller
//   Control and sequencing for the HH:MM clock datapath. Conditions the two raw
//   push-buttons (two-flop sync, debounce, rising-edge detect, auto-repeat),
//   owns the RUN / ADJ_MIN / ADJ_HOUR mode state machine, generates the seconds
//   enable, routes single-cycle increment strobes to the minute or hour counters,
//   and drives the per-digit blink masks and the colon dot.
//
// Ports
//   clock        in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-low
//   adv_btn_raw  in   raw advance-mode button (asynchronous, active-high)
//   inc_btn_raw  in   raw increment button (asynchronous, active-high)
//   mode         out  0=RUN, 1=ADJ_MIN, 2=ADJ_HOUR
//   sec_tick     out  one-cycle seconds enable, RUN only
//   clr_sec      out  one-cycle pulse on RUN -> ADJ_MIN
//   inc_min      out  one-cycle minute increment (ADJ_MIN only)
//   inc_hour     out  one-cycle hour increment (ADJ_HOUR only)
//   blink_mask   out  per-digit blank request {hour tens, hour units, min tens, min units}
//   dot          out  colon segment
module clock_mode_controller #(
    parameter int TICK_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_START    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       adv_btn_raw,
    input  logic       inc_btn_raw,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       clr_sec,
    output logic       inc_min,
    output logic       inc_hour,
    output logic [3:0] blink_mask,
    output logic       dot
);

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_ADJ_MIN  = 2'd1;
    localparam logic [1:0] MODE_ADJ_HOUR = 2'd2;

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TD_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BL_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int HOLD_W = $clog2(REPEAT_START + REPEAT_PERIOD);

    // Index 0 = advance button, index 1 = increment button.
    logic [1:0] raw_btn;
    logic [1:0] rise;
    logic [1:0] warm_reg;
    logic       inc_level;

    assign raw_btn = {inc_btn_raw, adv_btn_raw};

    // Marks when the synchronizer outputs carry real post-reset samples, so a
    // button's "released" state is judged on true pin values, not cleared flops.
    always_ff @(posedge clock) begin
        if (!reset) warm_reg <= 2'b00;
        else        warm_reg <= {warm_reg[0], 1'b1};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            deb_reg;
            logic            deb_prev_reg;
            logic            lock_reg;
            logic [DB_W-1:0] deb_cnt_reg;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    deb_reg      <= 1'b0;
                    deb_prev_reg <= 1'b0;
                    deb_cnt_reg  <= '0;
                    lock_reg     <= 1'b1;
                end else begin
                    sync1_reg    <= raw_btn[gi];
                    sync2_reg    <= sync1_reg;
                    deb_prev_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_reg     <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                    // A button held through reset stays locked until it has
                    // been seen released; its debounced rise is not an event.
                    if (lock_reg && warm_reg[1] && !sync2_reg && !deb_reg)
                        lock_reg <= 1'b0;
                end
            end

            assign rise[gi] = deb_reg & ~deb_prev_reg & ~lock_reg;
        end
    endgenerate

    assign inc_level = g_btn[1].deb_reg;

    logic              adv_rise;
    logic              inc_rise;
    logic [1:0]        mode_reg, mode_next;
    logic              sec_tick_reg, clr_sec_reg, inc_min_reg, inc_hour_reg, dot_reg;
    logic [3:0]        blink_mask_reg, blink_mask_next;
    logic [TD_W-1:0]   presc_reg, presc_next;
    logic              tick_next;
    logic [BL_W-1:0]   blink_cnt_reg, blink_cnt_next;
    logic              phase_reg, phase_next;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              hold_active_reg;
    logic              repeat_fire;
    logic              inc_fire;
    logic              run_steady;

    assign adv_rise = rise[0];
    assign inc_rise = rise[1];

    always_comb begin
        mode_next = mode_reg;
        if (adv_rise) begin
            case (mode_reg)
                MODE_RUN:     mode_next = MODE_ADJ_MIN;
                MODE_ADJ_MIN: mode_next = MODE_ADJ_HOUR;
                default:      mode_next = MODE_RUN;
            endcase
        end
    end

    // Auto-repeat fires at hold count REPEAT_START; the counter then cycles
    // through REPEAT_START..REPEAT_START+REPEAT_PERIOD-1 so it hits the fire
    // value once per period without needing a modulo.
    assign repeat_fire = hold_active_reg && inc_level &&
                         (hold_cnt_reg == HOLD_W'(REPEAT_START));
    // A mode change in the same cycle wins over any increment.
    assign inc_fire    = (inc_rise || repeat_fire) && !adv_rise;

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_active_reg <= 1'b0;
            hold_cnt_reg    <= '0;
        end else if (adv_rise || !inc_level) begin
            hold_active_reg <= 1'b0;
            hold_cnt_reg    <= '0;
        end else if (inc_rise) begin
            hold_active_reg <= 1'b1;
            hold_cnt_reg    <= '0;
        end else if (hold_active_reg) begin
            if (hold_cnt_reg == HOLD_W'(REPEAT_START + REPEAT_PERIOD - 1))
                hold_cnt_reg <= HOLD_W'(REPEAT_START);
            else
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
    end

    // The prescaler only runs while RUN is both the current and next mode, so
    // it is parked at 0 on the entry edge and the first tick is a full period on.
    assign run_steady = (mode_reg == MODE_RUN) && (mode_next == MODE_RUN);

    always_comb begin
        presc_next = '0;
        tick_next  = 1'b0;
        if (run_steady) begin
            if (presc_reg == TD_W'(TICK_DIV - 1)) tick_next = 1'b1;
            else                                  presc_next = presc_reg + 1'b1;
        end
    end

    always_comb begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
        phase_next     = phase_reg;
        if (mode_next == MODE_RUN || adv_rise || inc_level) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (blink_cnt_reg == BL_W'(BLINK_HALF - 1)) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end
    end

    always_comb begin
        blink_mask_next = 4'b0000;
        if (phase_next) begin
            if (mode_next == MODE_ADJ_MIN)  blink_mask_next = 4'b0011;
            if (mode_next == MODE_ADJ_HOUR) blink_mask_next = 4'b1100;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode_reg       <= MODE_RUN;
            sec_tick_reg   <= 1'b0;
            clr_sec_reg    <= 1'b0;
            inc_min_reg    <= 1'b0;
            inc_hour_reg   <= 1'b0;
            blink_mask_reg <= 4'b0000;
            dot_reg        <= 1'b1;
            presc_reg      <= '0;
            blink_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
        end else begin
            mode_reg       <= mode_next;
            sec_tick_reg   <= tick_next;
            clr_sec_reg    <= adv_rise && (mode_reg == MODE_RUN);
            inc_min_reg    <= inc_fire && (mode_reg == MODE_ADJ_MIN);
            inc_hour_reg   <= inc_fire && (mode_reg == MODE_ADJ_HOUR);
            blink_mask_reg <= blink_mask_next;
            presc_reg      <= presc_next;
            blink_cnt_reg  <= blink_cnt_next;
            phase_reg      <= phase_next;
            if (mode_next != MODE_RUN) dot_reg <= 1'b1;
            else if (tick_next)        dot_reg <= ~dot_reg;
        end
    end

    assign mode       = mode_reg;
    assign sec_tick   = sec_tick_reg;
    assign clr_sec    = clr_sec_reg;
    assign inc_min    = inc_min_reg;
    assign inc_hour   = inc_hour_reg;
    assign blink_mask = blink_mask_reg;
    assign dot        = dot_reg;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Testbench for clock_mode_controller with small timing parameters.
// Strobe outputs (clr_sec, inc_min, inc_hour) are checked by a scoreboard:
// stimulus pushes the expected strobe kind and cycle, a monitor pops on every
// strobe it sees. Levels (mode, sec_tick, dot, blink_mask) are checked inline.
module tb_clock_mode_controller;

    localparam int KIND_CLR  = 0;
    localparam int KIND_MIN  = 1;
    localparam int KIND_HOUR = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       adv_btn_raw;
    logic       inc_btn_raw;
    logic [1:0] mode;
    logic       sec_tick;
    logic       clr_sec;
    logic       inc_min;
    logic       inc_hour;
    logic [3:0] blink_mask;
    logic       dot;

    clock_mode_controller #(
        .TICK_DIV       (10),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_START   (20),
        .REPEAT_PERIOD  (8),
        .BLINK_HALF     (6)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .adv_btn_raw(adv_btn_raw),
        .inc_btn_raw(inc_btn_raw),
        .mode       (mode),
        .sec_tick   (sec_tick),
        .clr_sec    (clr_sec),
        .inc_min    (inc_min),
        .inc_hour   (inc_hour),
        .blink_mask (blink_mask),
        .dot        (dot)
    );

    always #5 clock = ~clock;

    // Number of rising edges seen so far; at a falling edge it names the
    // edge whose results are being observed.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;
    logic [2:0] pulses;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    function automatic int blink_exp(input int c, input int base, input int val);
        if (c < base) return 0;
        return (((c - base) / 6) % 2 == 0) ? val : 0;
    endfunction

    // Scoreboard monitor
    always @(negedge clock) begin
        pulses = {inc_hour, inc_min, clr_sec};
        if (inc_min || inc_hour)
            check("min_hour_exclusive", int'(inc_min & inc_hour), 0);
        for (int k = 0; k < 3; k++) begin
            if (pulses[k]) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected none", k, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_kind", k, mon_e.kind);
                    check("strobe_cycle", cyc, mon_e.cyc);
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_strobe: got nothing, expected kind %0d at cycle %0d", mon_e.kind, mon_e.cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e1, e2, e3, e4, e5, e6, r;
        reset       = 1'b0;
        adv_btn_raw = 1'b0;
        inc_btn_raw = 1'b0;

        // Reset held for three edges.
        repeat (3) @(negedge clock);
        check("rst_mode", int'(mode), 0);
        check("rst_sec_tick", int'(sec_tick), 0);
        check("rst_blink", int'(blink_mask), 0);
        check("rst_dot", int'(dot), 1);
        reset = 1'b1;
        r = cyc;

        // RUN: tick every 10 cycles after release, dot toggles on each tick.
        for (int c = r + 1; c <= r + 30; c++) begin
            goto(c);
            check("run_sec_tick", int'(sec_tick), ((c - r) % 10 == 0) ? 1 : 0);
            if (c == r + 10) check("run_dot_t1", int'(dot), 0);
            if (c == r + 20) check("run_dot_t2", int'(dot), 1);
        end
        check("run_mode", int'(mode), 0);
        check("run_blink", int'(blink_mask), 0);

        // adv glitch of 3 samples: ignored.
        e = cyc + 1;
        adv_btn_raw = 1'b1;
        goto(e + 2);
        adv_btn_raw = 1'b0;
        goto(e + 14);
        check("glitch_mode", int'(mode), 0);

        // adv held 10 samples: ADJ_MIN and clr_sec 6 edges after first sample.
        e = cyc + 1;
        push_ev(e + 6, KIND_CLR);
        adv_btn_raw = 1'b1;
        goto(e + 5);
        check("adv1_mode_before", int'(mode), 0);
        goto(e + 6);
        check("adv1_mode", int'(mode), 1);
        check("adv1_dot", int'(dot), 1);
        goto(e + 9);
        adv_btn_raw = 1'b0;
        for (int c = e + 10; c <= e + 25; c += 3) begin
            goto(c);
            check("adj_sec_tick", int'(sec_tick), 0);
            check("adj_dot", int'(dot), 1);
        end

        // inc held 32 samples in ADJ_MIN: pulses at +6, then hold counts 20 and 28.
        e = cyc + 1;
        push_ev(e + 6, KIND_MIN);
        push_ev(e + 27, KIND_MIN);
        push_ev(e + 35, KIND_MIN);
        inc_btn_raw = 1'b1;
        goto(e + 10); check("hold_blink_a", int'(blink_mask), 0);
        goto(e + 20); check("hold_blink_b", int'(blink_mask), 0);
        goto(e + 30); check("hold_blink_c", int'(blink_mask), 0);
        goto(e + 31);
        inc_btn_raw = 1'b0;

        // Idle in ADJ_MIN: mask blinks 0011 with 6-cycle halves once inc is released.
        for (int c = e + 38; c <= e + 60; c++) begin
            goto(c);
            check("blink_min", int'(blink_mask), blink_exp(c, e + 43, 3));
        end

        // adv -> ADJ_HOUR, mask blinks 1100.
        e1 = cyc + 1;
        adv_btn_raw = 1'b1;
        goto(e1 + 5); check("adv2_mode_before", int'(mode), 1);
        goto(e1 + 6); check("adv2_mode", int'(mode), 2);
        check("adv2_blink", int'(blink_mask), 0);
        goto(e1 + 9);
        adv_btn_raw = 1'b0;
        for (int c = e1 + 10; c <= e1 + 30; c++) begin
            goto(c);
            check("blink_hour", int'(blink_mask), blink_exp(c, e1 + 12, 12));
        end

        // adv -> RUN, first tick 10 cycles after entry.
        e2 = cyc + 1;
        adv_btn_raw = 1'b1;
        goto(e2 + 6);
        check("adv3_mode", int'(mode), 0);
        check("adv3_blink", int'(blink_mask), 0);
        check("adv3_sec_tick", int'(sec_tick), 0);
        goto(e2 + 9);
        adv_btn_raw = 1'b0;
        for (int c = e2 + 10; c <= e2 + 16; c++) begin
            goto(c);
            check("reentry_sec_tick", int'(sec_tick), (c == e2 + 16) ? 1 : 0);
            if (c == e2 + 15) check("reentry_dot_pre", int'(dot), 1);
            if (c == e2 + 16) check("reentry_dot_post", int'(dot), 0);
        end

        // Back to ADJ_MIN.
        goto(cyc + 10);
        e = cyc + 1;
        push_ev(e + 6, KIND_CLR);
        adv_btn_raw = 1'b1;
        goto(e + 9);
        adv_btn_raw = 1'b0;
        goto(e + 20);
        check("to_min_mode", int'(mode), 1);

        // adv and inc rise together: mode change wins, inc dropped and no repeat.
        e3 = cyc + 1;
        adv_btn_raw = 1'b1;
        inc_btn_raw = 1'b1;
        goto(e3 + 5); check("simul_mode_before", int'(mode), 1);
        goto(e3 + 6); check("simul_mode", int'(mode), 2);
        goto(e3 + 9);
        adv_btn_raw = 1'b0;
        goto(e3 + 40);
        check("simul_mode_hold", int'(mode), 2);
        inc_btn_raw = 1'b0;
        goto(e3 + 55);

        // Reset while inc repeats in ADJ_HOUR; adv also pressed during reset.
        e4 = cyc + 1;
        push_ev(e4 + 6, KIND_HOUR);
        push_ev(e4 + 27, KIND_HOUR);
        inc_btn_raw = 1'b1;
        goto(e4 + 30);
        reset       = 1'b0;
        adv_btn_raw = 1'b1;
        goto(e4 + 31);
        check("midrst_mode", int'(mode), 0);
        check("midrst_blink", int'(blink_mask), 0);
        check("midrst_dot", int'(dot), 1);
        check("midrst_inc_hour", int'(inc_hour), 0);
        check("midrst_sec_tick", int'(sec_tick), 0);
        goto(e4 + 32);
        reset = 1'b1;
        r = cyc;
        // Buttons held through reset produce nothing until released.
        goto(r + 25);
        check("locked_adv_mode", int'(mode), 0);
        adv_btn_raw = 1'b0;
        goto(r + 40);

        e5 = cyc + 1;
        push_ev(e5 + 6, KIND_CLR);
        adv_btn_raw = 1'b1;
        goto(e5 + 9);
        adv_btn_raw = 1'b0;
        goto(e5 + 20);
        check("post_rst_mode", int'(mode), 1);
        inc_btn_raw = 1'b0;
        goto(cyc + 15);

        // Fresh inc press after release works again.
        e6 = cyc + 1;
        push_ev(e6 + 6, KIND_MIN);
        inc_btn_raw = 1'b1;
        goto(e6 + 9);
        inc_btn_raw = 1'b0;
        goto(e6 + 25);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
